// File: rtl/fixed_act_pkg.sv
// ----------------------------------------------------------------------------
// fixed_act_pkg
//   Shared helpers for the fixed-point activation front end.
//   - cast_shift : right-shift amount that moves IN_P1 fractional bits to OUT_P1.
//   - above_max / below_min : width-generic saturation tests. The caller
//     sign-extends its value to 64 bits, so one function serves any lane width
//     up to 63 bits.
// ----------------------------------------------------------------------------
package fixed_act_pkg;

  localparam int unsigned CAST_MAX_W = 64;

  function automatic int cast_shift(input int in_frac, input int out_frac);
    return in_frac - out_frac;
  endfunction

  // True when y exceeds the largest value representable in out_w signed bits.
  function automatic logic above_max(input logic signed [CAST_MAX_W-1:0] y,
                                     input int unsigned out_w);
    return y > ((64'sd1 <<< (out_w - 1)) - 64'sd1);
  endfunction

  // True when y is below the most negative value representable in out_w bits.
  function automatic logic below_min(input logic signed [CAST_MAX_W-1:0] y,
                                     input int unsigned out_w);
    return y < -(64'sd1 <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/act_skid_buffer.sv
// ----------------------------------------------------------------------------
// act_skid_buffer
//   Output register plus one skid slot. Gives full throughput under
//   backpressure with a registered ready: ready is low exactly while the
//   skid slot holds a beat. Strict FIFO order, no drops, AXI-style hold.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_data/valid   upstream payload and valid
//   in_ready        registered accept (= ~skid_valid, 0 during reset)
//   out_data/valid  registered payload and valid
//   out_ready       downstream ready
// ----------------------------------------------------------------------------
module act_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         skid_next;
  logic         in_xfer;
  logic         load_out;
  logic         skid_fill;

  always_comb begin
    in_xfer   = in_valid & in_ready;
    // The output slot may take a new beat when it is empty or being drained.
    load_out  = ~out_valid | out_ready;
    // A beat accepted while the output slot is stalled parks in the skid.
    skid_fill = in_xfer & ~load_out;
    // in_ready is low while the skid is full, so in_xfer never coincides
    // with a full skid; a full skid empties on the next load.
    skid_next = skid_valid ? ~load_out : skid_fill;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      if (load_out) begin
        if (skid_valid) begin
          out_data  <= skid_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= in_xfer;
          if (in_xfer) out_data <= in_data;
        end
      end
      skid_valid <= skid_next;
      in_ready   <= ~skid_next;
    end
  end

  // NOTE: the skid payload is qualified by skid_valid, so it is deliberately
  // left out of reset; this keeps the reset net off the data flops.
  always_ff @(posedge clk) begin
    if (skid_fill) skid_data <= in_data;
  end

endmodule

// File: rtl/fixed_act_cast.sv
// ----------------------------------------------------------------------------
// fixed_act_cast
//   Elastic requantiser feeding the LUT-based activation stages. Each lane is
//   a signed IN_P0.IN_P1 value converted to signed OUT_P0.OUT_P1 by an
//   arithmetic right shift (floor) and saturation, then registered through
//   act_skid_buffer for full throughput under backpressure.
//   Build option FIXED_ACT_CAST_ROUND_EN: round-half-up before saturation
//   (adds 2^(SHIFT-1) to the sign-widened input before shifting).
// Ports
//   clk, rst          clock, synchronous active-high reset
//   data_in_0         N input lanes, IN_P0 bits each (lane 0 in LSBs)
//   data_in_0_valid   upstream valid
//   data_in_0_ready   registered accept
//   data_out_0        N requantised lanes, OUT_P0 bits each, registered
//   data_out_0_valid  registered output valid
//   data_out_0_ready  downstream ready
//   sat_count         accepted beats with any saturated lane, sticky at max
// ----------------------------------------------------------------------------
module fixed_act_cast
  import fixed_act_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int SAT_CNT_WIDTH               = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_IN_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
                                                 data_in_0,
  input  logic                                   data_in_0_valid,
  output logic                                   data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
                                                 data_out_0,
  output logic                                   data_out_0_valid,
  input  logic                                   data_out_0_ready,
  output logic [SAT_CNT_WIDTH-1:0]               sat_count
);

  localparam int IN_P0 = DATA_IN_0_PRECISION_0;
  localparam int OUT_P0 = DATA_OUT_0_PRECISION_0;
  localparam int N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int SHIFT = cast_shift(DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);
  // One extra sign bit so the rounding add can never wrap.
  localparam int W = IN_P0 + 1;

  localparam logic [OUT_P0-1:0] LANE_MAX = {1'b0, {(OUT_P0-1){1'b1}}};
  localparam logic [OUT_P0-1:0] LANE_MIN = {1'b1, {(OUT_P0-1){1'b0}}};

  if (SHIFT < 0 || OUT_P0 > IN_P0) begin : g_bad_cfg
    $error("fixed_act_cast: output format must not be wider or finer than input");
  end

  logic [N*OUT_P0-1:0] cast_data;
  logic [N-1:0]        lane_sat;
  logic                sat_any;
  logic                in_xfer;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [W-1:0] x_w;
    logic signed [W-1:0] y_w;
    logic                hi;
    logic                lo;

    assign x_w = {data_in_0[i*IN_P0+IN_P0-1], data_in_0[i*IN_P0 +: IN_P0]};

`ifdef FIXED_ACT_CAST_ROUND_EN
    // Half an output LSB; evaluates to 0 when SHIFT is 0.
    localparam logic signed [W-1:0] RND_ADD = W'((64'd1 << SHIFT) >> 1);
    assign y_w = (x_w + RND_ADD) >>> SHIFT;
`else
    assign y_w = x_w >>> SHIFT;
`endif

    assign hi = above_max(64'(y_w), OUT_P0);
    assign lo = below_min(64'(y_w), OUT_P0);

    assign cast_data[i*OUT_P0 +: OUT_P0] = hi ? LANE_MAX :
                                           lo ? LANE_MIN : y_w[OUT_P0-1:0];
    assign lane_sat[i] = hi | lo;
  end

  assign sat_any = |lane_sat;
  assign in_xfer = data_in_0_valid & data_in_0_ready;

  act_skid_buffer #(
    .W (N*OUT_P0)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (cast_data),
    .in_valid  (data_in_0_valid),
    .in_ready  (data_in_0_ready),
    .out_data  (data_out_0),
    .out_valid (data_out_0_valid),
    .out_ready (data_out_0_ready)
  );

  // Counts at acceptance time, so a beat is counted once even if it waits
  // in the skid slot; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (in_xfer && sat_any && (sat_count != '1)) begin
      sat_count <= sat_count + SAT_CNT_WIDTH'(1);
    end
  end

endmodule
